divider_scheduler: RTL and testbench

Shared-prescaler clock-divider controller. One prescaler divides input_clk into a common tick. CHANNELS independent divided outputs each toggle every programmable number of ticks. A valid/ready configuration port sets or changes a channel's period and enable. Changes are applied only on a tick boundary, so outputs never glitch mid-count. It replaces per-LED fixed dividers in the top level with one runtime-configurable resource.

---
 rtl/divider_scheduler_if.sv | 27 ++
 rtl/divider_scheduler.sv | 134 +++++++++++++
 tb/tb_divider_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/divider_scheduler_if.sv
// rtl/divider_scheduler_if.sv - configuration handshake bundle for divider_scheduler
interface divider_scheduler_if #(
    parameter int CHAN_WIDTH = 2,
    parameter int CNT_WIDTH  = 16
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [CHAN_WIDTH-1:0] cfg_chan;
    logic [CNT_WIDTH-1:0]  cfg_period;
    logic                  cfg_enable;

    modport master (
        output cfg_valid,
        input  cfg_ready,
        output cfg_chan,
        output cfg_period,
        output cfg_enable
    );

    modport slave (
        input  cfg_valid,
        output cfg_ready,
        input  cfg_chan,
        input  cfg_period,
        input  cfg_enable
    );
endinterface

// File: rtl/divider_scheduler.sv
// rtl/divider_scheduler.sv - shared-prescaler multi-channel clock divider with tick-aligned config
module divider_scheduler #(
    parameter int CHANNELS   = 4,
    parameter int PRESCALE   = 12000,
    parameter int PRE_WIDTH  = 14,
    parameter int CNT_WIDTH  = 16,
    parameter int CHAN_WIDTH = 2
) (
    input  logic                 input_clk,
    input  logic                 input_rst,
    divider_scheduler_if.slave   cfg,
    output logic                 tick,
    output logic [CHANNELS-1:0]  output_clk,
    output logic [CHANNELS-1:0]  chan_active
);

    localparam logic [PRE_WIDTH-1:0] PRE_MAX = PRE_WIDTH'(PRESCALE - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_apply;

    logic [PRE_WIDTH-1:0]  r_pre;
    logic                  r_tick;

    logic [CHAN_WIDTH-1:0] r_chan;
    logic [CNT_WIDTH-1:0]  r_cfg_period;
    logic                  r_cfg_enable;

    logic [CNT_WIDTH-1:0]  r_period [CHANNELS];
    logic [CNT_WIDTH-1:0]  r_count  [CHANNELS];
    logic [CHANNELS-1:0]   r_out;
    logic [CHANNELS-1:0]   r_active;

    // tick is registered so it is high for the cycle after the counter sits at PRE_MAX
    always_ff @(posedge input_clk or posedge input_rst) begin
        if (input_rst) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pre == PRE_MAX);
            r_pre  <= (r_pre == PRE_MAX) ? '0 : r_pre + PRE_WIDTH'(1);
        end
    end

    always_ff @(posedge input_clk or posedge input_rst) begin
        if (input_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_apply     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (r_tick) begin
                    w_apply     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge input_clk or posedge input_rst) begin
        if (input_rst) begin
            r_chan       <= '0;
            r_cfg_period <= '0;
            r_cfg_enable <= 1'b0;
        end else if (w_accept) begin
            r_chan       <= cfg.cfg_chan;
            r_cfg_period <= cfg.cfg_period;
            r_cfg_enable <= cfg.cfg_enable;
        end
    end

    // An apply to a channel takes precedence over its own tick update; out-of-range channels match nothing
    always_ff @(posedge input_clk or posedge input_rst) begin
        if (input_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_period[c] <= '0;
                r_count[c]  <= '0;
            end
            r_out    <= '0;
            r_active <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_apply && (int'(r_chan) == c)) begin
                    r_period[c] <= r_cfg_period;
                    r_out[c]    <= 1'b0;
                    if (r_cfg_enable && (r_cfg_period != '0)) begin
                        r_count[c]  <= r_cfg_period - CNT_WIDTH'(1);
                        r_active[c] <= 1'b1;
                    end else begin
                        r_count[c]  <= '0;
                        r_active[c] <= 1'b0;
                    end
                end else if (r_tick && r_active[c] && (r_period[c] != '0)) begin
                    if (r_count[c] == '0) begin
                        r_out[c]   <= ~r_out[c];
                        r_count[c] <= r_period[c] - CNT_WIDTH'(1);
                    end else begin
                        r_count[c] <= r_count[c] - CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign cfg.cfg_ready = w_ready;
    assign tick          = r_tick;
    assign output_clk    = r_out;
    assign chan_active   = r_active;

endmodule

// File: tb/tb_divider_scheduler.sv
// tb/tb_divider_scheduler.sv - directed self-checking bench for divider_scheduler
module tb_divider_scheduler;

    localparam int CHANNELS   = 3;
    localparam int PRESCALE   = 4;
    localparam int PRE_WIDTH  = 4;
    localparam int CNT_WIDTH  = 16;
    localparam int CHAN_WIDTH = 2;

    logic                clk;
    logic                rst;
    logic                tick;
    logic [CHANNELS-1:0] output_clk;
    logic [CHANNELS-1:0] chan_active;

    int n_checks;
    int n_errors;
    int n;

    divider_scheduler_if #(.CHAN_WIDTH(CHAN_WIDTH), .CNT_WIDTH(CNT_WIDTH)) cfg_bus ();

    divider_scheduler #(
        .CHANNELS  (CHANNELS),
        .PRESCALE  (PRESCALE),
        .PRE_WIDTH (PRE_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .CHAN_WIDTH(CHAN_WIDTH)
    ) dut (
        .input_clk  (clk),
        .input_rst  (rst),
        .cfg        (cfg_bus),
        .tick       (tick),
        .output_clk (output_clk),
        .chan_active(chan_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        n++;
    endtask

    task automatic drive(input logic [1:0] ch, input logic [15:0] per, input logic en);
        cfg_bus.cfg_valid  = 1'b1;
        cfg_bus.cfg_chan   = ch;
        cfg_bus.cfg_period = per;
        cfg_bus.cfg_enable = en;
    endtask

    // ch0 P=2 applied at edge 5: first toggle high at edge 13, 16-cycle square wave
    function automatic logic out0_exp(input int k);
        return (k >= 13) && (((k - 13) / 8) % 2 == 0);
    endfunction

    // ch1 P=1 applied at edge 29: first toggle high at edge 33, 8-cycle square wave
    function automatic logic out1_exp(input int k);
        return (k >= 33) && (((k - 33) / 4) % 2 == 0);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d got=timeout exp=finish", n);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        n        = 0;
        rst      = 1'b1;
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_chan   = '0;
        cfg_bus.cfg_period = '0;
        cfg_bus.cfg_enable = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_out",    32'(output_clk),  32'h0);
        check("rst_active", 32'(chan_active), 32'h0);
        check("rst_ready",  32'(cfg_bus.cfg_ready), 32'h1);
        check("rst_tick",   32'(tick),        32'h0);

        // Phase A: ch0 P=2 written for edge 1
        rst = 1'b0;
        drive(2'd0, 16'd2, 1'b1);
        while (n < 24) begin
            step();
            if (n == 1) cfg_bus.cfg_valid = 1'b0;
            check("a_tick",   32'(tick),               32'(n % 4 == 0));
            check("a_ready",  32'(cfg_bus.cfg_ready),  32'(n >= 5));
            check("a_active", 32'(chan_active),        32'(n >= 5));
            check("a_out",    32'(output_clk),         32'(out0_exp(n)));
        end

        // Phase B: ch1 P=1 written during a tick cycle, so it waits for the following tick
        drive(2'd1, 16'd1, 1'b1);
        while (n < 44) begin
            step();
            if (n == 25) cfg_bus.cfg_valid = 1'b0;
            check("b_tick",   32'(tick),              32'(n % 4 == 0));
            check("b_ready",  32'(cfg_bus.cfg_ready), 32'(n >= 29));
            check("b_active", 32'(chan_active),       32'({1'b0, n >= 29, 1'b1}));
            check("b_out",    32'(output_clk),        32'({1'b0, out1_exp(n), out0_exp(n)}));
        end

        // Phase C: disable ch0 in the middle of its high phase
        step();
        step();
        drive(2'd0, 16'd5, 1'b0);
        while (n < 92) begin
            step();
            if (n == 47) cfg_bus.cfg_valid = 1'b0;
            check("c_ready",  32'(cfg_bus.cfg_ready), 32'(n >= 49));
            check("c_active", 32'(chan_active),       32'({1'b0, 1'b1, n < 49}));
            check("c_out",    32'(output_clk),        32'({1'b0, out1_exp(n), (n < 49) && out0_exp(n)}));
        end

        // Phase D: period 0 with enable 1 on ch1 stops it like a disable
        drive(2'd1, 16'd0, 1'b1);
        while (n < 137) begin
            step();
            if (n == 93) cfg_bus.cfg_valid = 1'b0;
            check("d_ready",  32'(cfg_bus.cfg_ready), 32'(n >= 97));
            check("d_active", 32'(chan_active),       32'({1'b0, n < 97, 1'b0}));
            check("d_out",    32'(output_clk),        32'({1'b0, (n < 97) && out1_exp(n), 1'b0}));
        end

        // Phase E: valid held across two writes; second targets out-of-range channel 3
        drive(2'd2, 16'd1, 1'b1);
        while (n < 149) begin
            step();
            if (n == 138) cfg_bus.cfg_chan = 2'd3;
            check("e_ready",  32'(cfg_bus.cfg_ready), 32'((n == 141) || (n >= 145)));
            check("e_active", 32'(chan_active),       32'((n >= 141) ? 3'b100 : 3'b000));
            check("e_out",    32'(output_clk),        32'(((n >= 145) && (n <= 148)) ? 3'b100 : 3'b000));
            check("e_tick",   32'(tick),              32'(n % 4 == 0));
            if (n == 142) cfg_bus.cfg_valid = 1'b0;
        end

        // Phase F: reset while a write is pending and ch2 is high
        while (n < 153) step();
        drive(2'd0, 16'd1, 1'b1);
        step();
        check("f_pend_ready", 32'(cfg_bus.cfg_ready), 32'h0);
        check("f_pre_out",    32'(output_clk),        32'h4);
        #2 rst = 1'b1;
        #1;
        check("f_rst_out",    32'(output_clk),        32'h0);
        check("f_rst_active", 32'(chan_active),       32'h0);
        check("f_rst_tick",   32'(tick),              32'h0);
        check("f_rst_ready",  32'(cfg_bus.cfg_ready), 32'h1);
        cfg_bus.cfg_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n   = 0;
        while (n < 12) begin
            step();
            check("g_tick",   32'(tick),              32'(n % 4 == 0));
            check("g_ready",  32'(cfg_bus.cfg_ready), 32'h1);
            check("g_active", 32'(chan_active),       32'h0);
            check("g_out",    32'(output_clk),        32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
